// File: rtl/tick_scheduler.sv
// Shared-prescaler timebase: issues game, animation and seconds clock-enable
// strobes on CLOCK_50, with central pause and single-step control.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | prescaler and channel counters advance, strobes issued
// ST_PAUSED | all counters frozen, strobes held low, waits for step/resume
// ST_STEP   | one-cycle forced game_tick + step_ack, counters untouched
module tick_scheduler #(
  parameter int BASE_DIV = 50000,
  parameter int DIV_FAST = 40,
  parameter int DIV_MED  = 100,
  parameter int DIV_SLOW = 1000,
  parameter int ANIM_DIV = 100,
  parameter int SEC_DIV  = 1000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] rate_sel,
  input  logic       pause,
  input  logic       step_req,
  output logic       step_ack,
  output logic       game_tick,
  output logic       anim_tick,
  output logic       sec_tick,
  output logic       paused
);

  localparam int GAME_MAX = (DIV_FAST > DIV_MED) ?
                            ((DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW) :
                            ((DIV_MED > DIV_SLOW) ? DIV_MED : DIV_SLOW);
  localparam int BW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int GW = (GAME_MAX > 1) ? $clog2(GAME_MAX) : 1;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SW = (SEC_DIV > 1)  ? $clog2(SEC_DIV)  : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    rate_q;
  logic          step_req_q;
  logic [BW-1:0] base_cnt;
  logic [GW-1:0] game_cnt;
  logic [AW-1:0] anim_cnt;
  logic [SW-1:0] sec_cnt;
  logic [GW-1:0] game_last;

  logic advance;
  logic base_tick;
  logic rate_chg;
  logic step_take;
  logic game_wrap;
  logic anim_wrap;
  logic sec_wrap;
  logic game_tick_d;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_take = 1'b0;
    case (state)
      ST_RUN: begin
        if (pause) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_nxt = ST_RUN;
        end else if (step_req && !step_req_q) begin
          state_nxt = ST_STEP;
          step_take = 1'b1;
        end
      end
      ST_STEP: begin
        state_nxt = pause ? ST_PAUSED : ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    case (rate_q)
      2'b01:   game_last = GW'(DIV_FAST - 1);
      2'b10:   game_last = GW'(DIV_MED - 1);
      default: game_last = GW'(DIV_SLOW - 1);
    endcase
  end

  // A pause sampled in RUN already blocks this edge, so pause wins over a wrap.
  assign advance   = (state == ST_RUN) && !pause;
  assign base_tick = advance && (base_cnt == BW'(BASE_DIV - 1));
  assign rate_chg  = (rate_sel != rate_q);
  assign game_wrap = base_tick && !rate_chg && (rate_q != 2'b00) && (game_cnt == game_last);
  assign anim_wrap = base_tick && (anim_cnt == AW'(ANIM_DIV - 1));
  assign sec_wrap  = base_tick && (sec_cnt == SW'(SEC_DIV - 1));

  always_comb begin
    game_tick_d = 1'b0;
    if (step_take) begin
      game_tick_d = 1'b1;
    end else if (advance && !rate_chg) begin
      game_tick_d = (rate_q == 2'b00) || game_wrap;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      step_req_q <= 1'b0;
      step_ack   <= 1'b0;
      game_tick  <= 1'b0;
      anim_tick  <= 1'b0;
      sec_tick   <= 1'b0;
      paused     <= 1'b0;
    end else begin
      step_req_q <= step_req;
      step_ack   <= step_take;
      game_tick  <= game_tick_d;
      anim_tick  <= anim_wrap;
      sec_tick   <= sec_wrap;
      paused     <= (state_nxt != ST_RUN);
    end
  end

  // A rate change re-phases the prescaler too, so the new game period is
  // measured in full from the change rather than from the old base phase.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rate_q   <= rate_sel;
      base_cnt <= '0;
      game_cnt <= '0;
    end else if (advance) begin
      rate_q <= rate_sel;
      if (rate_chg || base_tick) begin
        base_cnt <= '0;
      end else begin
        base_cnt <= base_cnt + 1'b1;
      end
      if (rate_chg || (rate_q == 2'b00) || game_wrap) begin
        game_cnt <= '0;
      end else if (base_tick) begin
        game_cnt <= game_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      anim_cnt <= '0;
      sec_cnt  <= '0;
    end else begin
      if (anim_wrap) begin
        anim_cnt <= '0;
      end else if (base_tick) begin
        anim_cnt <= anim_cnt + 1'b1;
      end
      if (sec_wrap) begin
        sec_cnt <= '0;
      end else if (base_tick) begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed edge-position checks plus a randomized
// run compared cycle by cycle against an event-count reference model.
module tb_tick_scheduler;

  localparam int BASE_DIV = 4;
  localparam int DIV_FAST = 2;
  localparam int DIV_MED  = 3;
  localparam int DIV_SLOW = 5;
  localparam int ANIM_DIV = 3;
  localparam int SEC_DIV  = 5;

  localparam int M_RUN    = 0;
  localparam int M_PAUSED = 1;
  localparam int M_STEP   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic [1:0] rate_sel = 2'b00;
  logic       pause    = 1'b0;
  logic       step_req = 1'b0;
  logic       step_ack, game_tick, anim_tick, sec_tick, paused;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  logic [63:0] r_game, r_anim, r_sec, r_ack, r_paused;
  logic [4:0]  obs;

  // reference model: counts of active edges and base ticks
  int         m_st;
  logic [1:0] m_rate;
  bit         m_prev;
  int         n_base, n_gbt, n_bt;
  logic [4:0] exp_v;

  tick_scheduler #(
    .BASE_DIV(BASE_DIV), .DIV_FAST(DIV_FAST), .DIV_MED(DIV_MED),
    .DIV_SLOW(DIV_SLOW), .ANIM_DIV(ANIM_DIV), .SEC_DIV(SEC_DIV)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .rate_sel (rate_sel),
    .pause    (pause),
    .step_req (step_req),
    .step_ack (step_ack),
    .game_tick(game_tick),
    .anim_tick(anim_tick),
    .sec_tick (sec_tick),
    .paused   (paused)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int div_of(input logic [1:0] r);
    case (r)
      2'b01:   return DIV_FAST;
      2'b10:   return DIV_MED;
      default: return DIV_SLOW;
    endcase
  endfunction

  task automatic model_edge();
    bit rise, bt, e_game, e_anim, e_sec, e_ack;
    if (!resetn) begin
      m_st = M_RUN; m_rate = rate_sel; m_prev = 1'b0;
      n_base = 0; n_gbt = 0; n_bt = 0;
      exp_v = 5'b0;
    end else begin
      rise = step_req && !m_prev;
      e_game = 0; e_anim = 0; e_sec = 0; e_ack = 0;
      if (m_st == M_RUN && !pause) begin
        n_base++;
        bt = (n_base % BASE_DIV) == 0;
        if (bt) begin
          n_bt++;
          e_anim = (n_bt % ANIM_DIV) == 0;
          e_sec  = (n_bt % SEC_DIV) == 0;
        end
        if (rate_sel != m_rate) begin
          m_rate = rate_sel; n_base = 0; n_gbt = 0;
        end else if (m_rate == 2'b00) begin
          e_game = 1;
        end else if (bt) begin
          n_gbt++;
          e_game = (n_gbt % div_of(m_rate)) == 0;
        end
      end
      case (m_st)
        M_RUN:    if (pause) m_st = M_PAUSED;
        M_PAUSED: if (!pause) m_st = M_RUN;
                  else if (rise) begin m_st = M_STEP; e_game = 1; e_ack = 1; end
        default:  m_st = pause ? M_PAUSED : M_RUN;
      endcase
      exp_v = {e_ack, e_game, e_anim, e_sec, m_st != M_RUN};
      m_prev = step_req;
    end
  endtask

  task automatic tick();
    logic rst_at_edge;
    @(posedge CLOCK_50);
    rst_at_edge = resetn;
    model_edge();
    @(negedge CLOCK_50);
    obs = {step_ack, game_tick, anim_tick, sec_tick, paused};
    if (rst_at_edge) begin
      edge_n++;
      if (edge_n < 64) begin
        r_game[edge_n] = game_tick; r_anim[edge_n] = anim_tick;
        r_sec[edge_n] = sec_tick; r_ack[edge_n] = step_ack; r_paused[edge_n] = paused;
      end
    end
  endtask

  task automatic clear_rec();
    edge_n = 0;
    r_game = '0; r_anim = '0; r_sec = '0; r_ack = '0; r_paused = '0;
  endtask

  task automatic start_run(input logic [1:0] r);
    resetn = 1'b0; rate_sel = r; pause = 1'b0; step_req = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    clear_rec();
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0; rate_sel = 2'b00; pause = 1'b0; step_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b0);
      end
    end
    resetn = 1'b1;
    clear_rec();
    tick();
    n_checks++;
    if (obs !== 5'b01000) begin
      n_fail++; $display("FAIL reset_first_edge: got %b want %b", obs, 5'b01000);
    end
    step_req = 1'b0;
  endtask

  task automatic test_fast();
    start_run(2'b01);
    run_to(26);
    n_checks++;
    if (r_game !== ((64'd1 << 8) | (64'd1 << 16) | (64'd1 << 24))) begin
      n_fail++; $display("FAIL fast_game_edges: got %h want %h", r_game, (64'd1 << 8) | (64'd1 << 16) | (64'd1 << 24));
    end
    n_checks++;
    if (r_anim !== ((64'd1 << 12) | (64'd1 << 24))) begin
      n_fail++; $display("FAIL fast_anim_edges: got %h want %h", r_anim, (64'd1 << 12) | (64'd1 << 24));
    end
    n_checks++;
    if (r_sec !== (64'd1 << 20)) begin
      n_fail++; $display("FAIL fast_sec_edges: got %h want %h", r_sec, 64'd1 << 20);
    end
    n_checks++;
    if ((r_ack | r_paused) !== 64'd0) begin
      n_fail++; $display("FAIL fast_ack_paused: got %h want 0", r_ack | r_paused);
    end
  endtask

  task automatic test_rate_change();
    start_run(2'b00);
    run_to(9);
    rate_sel = 2'b11;
    run_to(32);
    n_checks++;
    if (r_game !== (64'h3FE | (64'd1 << 30))) begin
      n_fail++; $display("FAIL rate_change_game: got %h want %h", r_game, 64'h3FE | (64'd1 << 30));
    end
  endtask

  task automatic test_pause();
    start_run(2'b01);
    run_to(5);
    pause = 1'b1;
    run_to(25);
    pause = 1'b0;
    run_to(32);
    n_checks++;
    if (r_game !== (64'd1 << 29)) begin
      n_fail++; $display("FAIL pause_game: got %h want %h", r_game, 64'd1 << 29);
    end
    n_checks++;
    if ((r_anim | r_sec | r_ack) !== 64'd0) begin
      n_fail++; $display("FAIL pause_other_strobes: got %h want 0", r_anim | r_sec | r_ack);
    end
    n_checks++;
    if (r_paused !== ((64'd1 << 26) - (64'd1 << 6))) begin
      n_fail++; $display("FAIL pause_flag: got %h want %h", r_paused, (64'd1 << 26) - (64'd1 << 6));
    end
  endtask

  task automatic test_pause_on_wrap();
    start_run(2'b01);
    run_to(7);
    pause = 1'b1;
    run_to(11);
    pause = 1'b0;
    run_to(15);
    n_checks++;
    if (r_game !== (64'd1 << 13)) begin
      n_fail++; $display("FAIL pause_wrap_game: got %h want %h", r_game, 64'd1 << 13);
    end
    n_checks++;
    if (r_paused !== ((64'd1 << 12) - (64'd1 << 8))) begin
      n_fail++; $display("FAIL pause_wrap_flag: got %h want %h", r_paused, (64'd1 << 12) - (64'd1 << 8));
    end
  endtask

  task automatic test_step();
    logic [63:0] want_ack;
    want_ack = (64'd1 << 7) | (64'd1 << 9) | (64'd1 << 15);
    start_run(2'b11);
    run_to(3);
    pause = 1'b1;
    run_to(6);
    step_req = 1'b1; run_to(7);
    step_req = 1'b0; run_to(8);
    step_req = 1'b1; run_to(13);
    step_req = 1'b0; run_to(14);
    step_req = 1'b1; run_to(15);
    step_req = 1'b0; pause = 1'b0;
    run_to(34);
    n_checks++;
    if (r_ack !== want_ack) begin
      n_fail++; $display("FAIL step_ack_edges: got %h want %h", r_ack, want_ack);
    end
    n_checks++;
    if (r_game !== (want_ack | (64'd1 << 33))) begin
      n_fail++; $display("FAIL step_game_edges: got %h want %h", r_game, want_ack | (64'd1 << 33));
    end
    n_checks++;
    if (r_anim !== (64'd1 << 25) || r_sec !== (64'd1 << 33)) begin
      n_fail++; $display("FAIL step_anim_sec: got %h/%h want %h/%h", r_anim, r_sec, 64'd1 << 25, 64'd1 << 33);
    end
    n_checks++;
    if (r_paused !== ((64'd1 << 16) - (64'd1 << 4))) begin
      n_fail++; $display("FAIL step_paused: got %h want %h", r_paused, (64'd1 << 16) - (64'd1 << 4));
    end
  endtask

  task automatic test_reset_mid();
    start_run(2'b01);
    run_to(8);
    n_checks++;
    if (game_tick !== 1'b1) begin
      n_fail++; $display("FAIL midcount_pre: got %b want 1", game_tick);
    end
    resetn = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++; $display("FAIL midcount_reset: got %b want %b", obs, 5'b0);
    end
    resetn = 1'b1;
    clear_rec();
    run_to(3);
    pause = 1'b1; run_to(4);
    step_req = 1'b1; run_to(5);
    n_checks++;
    if (obs !== 5'b11001) begin
      n_fail++; $display("FAIL midstep_pre: got %b want %b", obs, 5'b11001);
    end
    resetn = 1'b0; step_req = 1'b0; pause = 1'b0;
    tick();
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++; $display("FAIL midstep_reset: got %b want %b", obs, 5'b0);
    end
    resetn = 1'b1;
    clear_rec();
    run_to(26);
    n_checks++;
    if (r_game !== ((64'd1 << 8) | (64'd1 << 16) | (64'd1 << 24)) ||
        r_anim !== ((64'd1 << 12) | (64'd1 << 24)) || r_sec !== (64'd1 << 20)) begin
      n_fail++; $display("FAIL resume_after_reset: got game %h anim %h sec %h", r_game, r_anim, r_sec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 79) == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      step_req = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got ack/game/anim/sec/paused %b want %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fast();
    test_rate_change();
    test_pause();
    test_pause_on_wrap();
    test_step();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
